// File: rtl/lux_pkg.sv
// Shared constants and state encodings for the lux_filter averaging pipeline.
package lux_pkg;

    localparam logic [31:0] LUX_SCALE_K    = 32'd54613;
    localparam logic [31:0] LUX_ROUND      = 32'd32768;

    localparam int          DEPTH_LOG2_MIN = 1;
    localparam int          DEPTH_LOG2_MAX = 5;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fill_state_t;

    typedef enum logic {
        DARK   = 1'b0,
        BRIGHT = 1'b1
    } hyst_state_t;

endpackage

// File: rtl/lux_scale.sv
// S1 of lux_filter: counts-to-lux conversion (raw/1.2, rounded) with its valid.
// LUX_SCALE_EN selects scaling; when undefined the raw count passes through.
module lux_scale
    import lux_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_data,
    input  logic        i_vld,
    output logic [15:0] o_data,
    output logic        o_vld
);

    logic [15:0] w_data_p0;
    logic [15:0] r_data_p1;
    logic        r_vld_p1;

`ifdef LUX_SCALE_EN
    // 54613/65536 ~= 1/1.2; the half-LSB offset rounds to nearest.
    function automatic logic [15:0] scale_round(input logic [15:0] raw);
        logic [31:0] prod;
        prod = {16'd0, raw} * LUX_SCALE_K + LUX_ROUND;
        return 16'(prod >> 16);
    endfunction

    assign w_data_p0 = scale_round(i_data);
`else
    assign w_data_p0 = i_data;
`endif

    // ---- S1 register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= i_vld;
            if (i_vld) begin
                r_data_p1 <= w_data_p0;
            end
        end
    end

    assign o_data = r_data_p1;
    assign o_vld  = r_vld_p1;

endmodule

// File: rtl/lux_filter.sv
// Lux conversion, 2^DEPTH_LOG2 moving average and hysteresis bright/dark flag.
// Scaling in S1 is enabled by defining LUX_SCALE_EN (see lux_scale).
module lux_filter
    import lux_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] lux_data,
    input  logic        lux_data_vld,
    input  logic [15:0] thr_high,
    input  logic [15:0] thr_low,
    output logic [15:0] lux_avg,
    output logic        lux_avg_vld,
    output logic        bright,
    output logic        bright_chg
);

    localparam int                  N         = 1 << DEPTH_LOG2;
    localparam int                  SUM_W     = 16 + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FILL_LAST = (DEPTH_LOG2 + 1)'(N - 1);
    localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2 + 1)'(N);

    if (DEPTH_LOG2 < DEPTH_LOG2_MIN || DEPTH_LOG2 > DEPTH_LOG2_MAX) begin : g_bad_depth
        $error("lux_filter: DEPTH_LOG2 out of range");
    end

    logic [15:0]           w_s_p1;
    logic                  w_vld_p1;
    logic [SUM_W-1:0]      r_sum_p2;
    logic [15:0]           r_buf [N];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_fill_cnt;
    logic                  r_vld_p2;
    fill_state_t           r_fill, w_fill_next;
    logic                  w_out_en_p1;
    logic [15:0]           w_avg_p2;
    logic [15:0]           r_avg_p3;
    logic                  r_vld_p3;
    hyst_state_t           r_hyst, w_hyst_next;
    logic                  w_chg_p2;
    logic                  r_chg_p3;

    // ---- S1: scale ----
    lux_scale u_scale (
        .clk    (clk),
        .reset  (reset),
        .i_data (lux_data),
        .i_vld  (lux_data_vld),
        .o_data (w_s_p1),
        .o_vld  (w_vld_p1)
    );

    // ---- S2: accumulate and fill tracking ----
    always_comb begin
        w_fill_next = r_fill;
        if (r_fill == FILL && w_vld_p1 && r_fill_cnt == FILL_LAST) begin
            w_fill_next = RUN;
        end
        // The sample that completes the window already produces an output.
        w_out_en_p1 = w_vld_p1 && (w_fill_next == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill <= FILL;
        end else begin
            r_fill <= w_fill_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum_p2   <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_vld_p2   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_vld_p2 <= w_out_en_p1;
            if (w_vld_p1) begin
                r_sum_p2        <= r_sum_p2 + SUM_W'(w_s_p1) - SUM_W'(r_buf[r_wr_ptr]);
                r_buf[r_wr_ptr] <= w_s_p1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                if (r_fill_cnt != FILL_FULL) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
            end
        end
    end

    // ---- S3: average output and hysteresis ----
    assign w_avg_p2 = r_sum_p2[SUM_W-1:DEPTH_LOG2];

    always_comb begin
        w_hyst_next = r_hyst;
        w_chg_p2    = 1'b0;
        if (r_vld_p2) begin
            case (r_hyst)
                DARK: begin
                    if (w_avg_p2 >= thr_high) begin
                        w_hyst_next = BRIGHT;
                        w_chg_p2    = 1'b1;
                    end
                end
                BRIGHT: begin
                    if (w_avg_p2 < thr_low) begin
                        w_hyst_next = DARK;
                        w_chg_p2    = 1'b1;
                    end
                end
                default: begin
                    w_hyst_next = DARK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hyst   <= DARK;
            r_chg_p3 <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_avg_p3 <= '0;
        end else begin
            r_hyst   <= w_hyst_next;
            r_chg_p3 <= w_chg_p2;
            r_vld_p3 <= r_vld_p2;
            if (r_vld_p2) begin
                r_avg_p3 <= w_avg_p2;
            end
        end
    end

    assign lux_avg     = r_avg_p3;
    assign lux_avg_vld = r_vld_p3;
    assign bright      = (r_hyst == BRIGHT);
    assign bright_chg  = r_chg_p3;

endmodule

// File: tb/tb_lux_filter.sv
// Directed bench for lux_filter; expected values follow the LUX_SCALE_EN setting.
module tb_lux_filter;

`ifdef LUX_SCALE_EN
    localparam logic [15:0] R1000  = 16'd1200;
    localparam logic [15:0] R2000  = 16'd2400;
    localparam logic [15:0] R1500  = 16'd1800;
    localparam logic [15:0] R900   = 16'd1080;
    localparam logic [15:0] R799   = 16'd959;
    localparam logic [15:0] E1200  = 16'd1000;
    localparam logic [15:0] E65535 = 16'd54612;
    localparam logic [15:0] E120   = 16'd100;
`else
    localparam logic [15:0] R1000  = 16'd1000;
    localparam logic [15:0] R2000  = 16'd2000;
    localparam logic [15:0] R1500  = 16'd1500;
    localparam logic [15:0] R900   = 16'd900;
    localparam logic [15:0] R799   = 16'd799;
    localparam logic [15:0] E1200  = 16'd1200;
    localparam logic [15:0] E65535 = 16'd65535;
    localparam logic [15:0] E120   = 16'd120;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] lux_data;
    logic        lux_data_vld;
    logic [15:0] thr_high;
    logic [15:0] thr_low;
    logic [15:0] lux_avg;
    logic        lux_avg_vld;
    logic        bright;
    logic        bright_chg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] seq_exp [8] = '{16'd1125, 16'd1250, 16'd1375, 16'd1500,
                                 16'd1625, 16'd1750, 16'd1875, 16'd2000};

    always #5 clk = ~clk;

    lux_filter #(.DEPTH_LOG2(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .lux_data     (lux_data),
        .lux_data_vld (lux_data_vld),
        .thr_high     (thr_high),
        .thr_low      (thr_low),
        .lux_avg      (lux_avg),
        .lux_avg_vld  (lux_avg_vld),
        .bright       (bright),
        .bright_chg   (bright_chg)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq({tag, " avg"},    32'(lux_avg),     32'd0);
        check_eq({tag, " vld"},    32'(lux_avg_vld), 32'd0);
        check_eq({tag, " bright"}, 32'(bright),      32'd0);
        check_eq({tag, " chg"},    32'(bright_chg),  32'd0);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One strobe; output expected exactly 3 edges after the capturing edge.
    task automatic send(input logic [15:0] raw, input bit exp_out, input bit chk_avg,
                        input logic [15:0] exp_avg, input bit chk_flags, input bit exp_bright,
                        input bit exp_chg, input int gap, input string tag);
        @(negedge clk);
        lux_data     = raw;
        lux_data_vld = 1'b1;
        @(negedge clk);
        lux_data_vld = 1'b0;
        @(negedge clk);
        check_eq({tag, " early vld"}, 32'(lux_avg_vld), 32'd0);
        @(negedge clk);
        check_eq({tag, " vld"}, 32'(lux_avg_vld), 32'(exp_out));
        if (exp_out && chk_avg)
            check_eq({tag, " avg"}, 32'(lux_avg), 32'(exp_avg));
        if (exp_out && chk_flags) begin
            check_eq({tag, " bright"}, 32'(bright),     32'(exp_bright));
            check_eq({tag, " chg"},    32'(bright_chg), 32'(exp_chg));
        end
        @(negedge clk);
        check_eq({tag, " vld pulse"}, 32'(lux_avg_vld), 32'd0);
        if (chk_flags) begin
            check_eq({tag, " chg pulse"},   32'(bright_chg), 32'd0);
            check_eq({tag, " bright held"}, 32'(bright),     32'(exp_bright));
        end
        repeat (gap) @(negedge clk);
    endtask

    // Eight strobes of one value; only the last average is checked by value.
    task automatic fill(input logic [15:0] raw, input bit in_run, input logic [15:0] exp_avg,
                        input bit chk_flags, input bit mid_bright, input bit end_bright,
                        input bit end_chg, input int gap, input string tag);
        for (int i = 0; i < 7; i++)
            send(raw, in_run, 1'b0, 16'd0, chk_flags, mid_bright, 1'b0, gap, tag);
        send(raw, 1'b1, 1'b1, exp_avg, chk_flags, end_bright, end_chg, gap, tag);
    endtask

    initial begin
        reset        = 1'b0;
        lux_data     = '0;
        lux_data_vld = 1'b0;
        thr_high     = 16'hFFFF;
        thr_low      = 16'd0;
        repeat (3) @(negedge clk);
        check_eq("reset avg",    32'(lux_avg),     32'd0);
        check_eq("reset vld",    32'(lux_avg_vld), 32'd0);
        check_eq("reset bright", 32'(bright),      32'd0);
        check_eq("reset chg",    32'(bright_chg),  32'd0);
        reset = 1'b1;
        @(negedge clk);

        fill(16'd1200, 1'b0, E1200, 1'b0, 1'b0, 1'b0, 1'b0, 5, "first fill");

        fill(16'd65535, 1'b1, E65535, 1'b0, 1'b0, 1'b0, 1'b0, 0, "max raw");
        fill(16'd0,     1'b1, 16'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, "zero raw");
        fill(16'd120,   1'b1, E120,   1'b0, 1'b0, 1'b0, 1'b0, 0, "raw 120");

        fill(R1000, 1'b1, 16'd1000, 1'b0, 1'b0, 1'b0, 1'b0, 0, "pre stream");
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    lux_data     = R2000;
                    lux_data_vld = 1'b1;
                end
                @(negedge clk);
                lux_data_vld = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    check_eq($sformatf("stream vld %0d", k), 32'(lux_avg_vld), 32'd1);
                    check_eq($sformatf("stream avg %0d", k), 32'(lux_avg), 32'(seq_exp[k]));
                end
                @(negedge clk);
                check_eq("stream end vld", 32'(lux_avg_vld), 32'd0);
            end
        join
        repeat (3) @(negedge clk);

        do_reset("hyst reset");
        thr_high = 16'd1500;
        thr_low  = 16'd800;
        fill(R1000, 1'b0, 16'd1000, 1'b1, 1'b0, 1'b0, 1'b0, 0, "hyst 1000");
        fill(R1500, 1'b1, 16'd1500, 1'b1, 1'b0, 1'b1, 1'b1, 0, "hyst 1500");
        fill(R900,  1'b1, 16'd900,  1'b1, 1'b1, 1'b1, 1'b0, 0, "hyst 900");
        fill(R799,  1'b1, 16'd799,  1'b1, 1'b1, 1'b0, 1'b1, 0, "hyst 799");

        do_reset("pre partial");
        for (int i = 0; i < 5; i++)
            send(16'd120, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 0, "partial");
        do_reset("mid reset");
        fill(16'd1200, 1'b0, E1200, 1'b0, 1'b0, 1'b0, 1'b0, 0, "refill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lux_filter.md
# lux_filter

Downstream consumer of the BH1750 light-sensor driver: takes each 16-bit raw reading and its one-cycle valid pulse, converts counts to lux, keeps a moving average over the last 2^DEPTH_LOG2 readings, and drives a hysteresis bright/dark flag. Its outputs feed the display and control logic; a 3-cycle pipeline lets it accept a sample on every cycle.

## Interface
- DEPTH_LOG2, 3: log2 of averaging window (legal 1..5; window = 8 by default)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- lux_data  input  16  raw sensor count from the driver
- lux_data_vld  input  1  single-cycle strobe; lux_data valid this cycle
- thr_high  input  16  bright threshold (lux units), sampled at compare time
- thr_low  input  16  dark threshold; thr_low <= thr_high required, otherwise behaviour undefined
- lux_avg  output  16  windowed average
- lux_avg_vld  output  1  single-cycle strobe, lux_avg updated
- bright  output  1  hysteresis flag, 1 = bright
- bright_chg  output  1  single-cycle strobe when bright toggles

## Operation
- Stage S1 (scale): on lux_data_vld, s = (lux_data*54613 + 32768) >> 16 (raw/1.2, rounded), registered with valid s1_vld.
- Stage S2 (accumulate): on s1_vld, sum <= sum + s - buf[wr_ptr]; buf[wr_ptr] <= s; wr_ptr <= wr_ptr+1 (wraps mod 2^DEPTH_LOG2). sum is 16+DEPTH_LOG2 bits and never overflows. Read of the old entry and write of the new entry happen in the same cycle.
- Fill FSM (S2): FILL → RUN once fill_cnt reaches 2^DEPTH_LOG2 accepted samples; fill_cnt saturates. buf is zero after reset, so partial sums stay exact.
- Stage S3 (output): when s2_vld is set in RUN (including the sample that completes FILL), lux_avg <= sum >> DEPTH_LOG2 (truncating) and lux_avg_vld pulses. No lux_avg_vld is issued in FILL.
- Hysteresis FSM, updated only in the lux_avg_vld cycle using the new average:
  - DARK → BRIGHT when avg >= thr_high.
  - BRIGHT → DARK when avg < thr_low.
  - bright_chg pulses in the same cycle as the transition.

## Timing
- Reset values: lux_avg=0, lux_avg_vld=0, bright=0 (DARK), bright_chg=0, sum=0, buf all 0, wr_ptr=0, fill_cnt=0, FSM=FILL.
- Latency: lux_data_vld at cycle T → lux_avg_vld and bright/bright_chg at T+3.
- Throughput: one sample per cycle. Back-to-back strobes each produce their own output (in RUN).
- bright and bright_chg are registered alongside lux_avg, so there is no extra cycle.
- Threshold changes take effect at the next lux_avg_vld; bright is never re-evaluated without one.
- Reset asserted mid-operation: every stage, the buffer and both FSMs clear immediately; in-flight samples are discarded and the 2^DEPTH_LOG2-sample fill restarts.
- avg == thr_high while DARK → BRIGHT. avg == thr_low while BRIGHT → stays BRIGHT.

## Configuration
- LUX_SCALE_EN defined: S1 applies the /1.2 scaling above.
- LUX_SCALE_EN undefined: S1 registers lux_data unchanged, so averages and thresholds are in raw counts.
- Latency stays 3 cycles in both cases.

## Structure
- Shared package lux_pkg holds:
  - LUX_SCALE_K=54613, LUX_ROUND=32768
  - FILL/RUN and DARK/BRIGHT state encodings
  - the DEPTH_LOG2 legal range
- One sub-module, lux_scale: the S1 multiply/round/register stage with its valid. This is where the LUX_SCALE_EN switch lives.

## Test plan
- Reset, then 8 strobes of raw 1200 spaced 10 cycles apart (LUX_SCALE_EN on) → no lux_avg_vld for strobes 1–7; 3 cycles after strobe 8, lux_avg=1000 with a one-cycle lux_avg_vld.
- Scale corners, each checked after the window is filled with that value: raw 65535 → 54612; raw 0 → 0; raw 120 → 100.
- Window full of 1000, then 8 strobes of 2000 on consecutive cycles → outputs on consecutive cycles: 1125, 1250, … 2000.
- thr_high=1500, thr_low=800; averages 1000 → 1500 → 900 → 799 → bright goes 0 → 1 (bright_chg pulse) → 1 → 0 (bright_chg pulse).
- Reset pulsed after 5 of 8 fill samples → outputs return to reset values; the next output appears only after 8 fresh samples.
- LUX_SCALE_EN undefined, window of raw 1200 → lux_avg=1200.
